// File: rtl/data_memory_pkg.sv
// Shared types for the store-side data memory path: op widths, buffer entries, drain FSM.
// Used by store_buffer (optional STORE_BUFFER_FORWARD_EN load forwarding).
package data_memory_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } mem_op_width_t;

    localparam int STORE_BUFFER_DEPTH = 4;
    localparam int SB_ADDR_WIDTH      = 32;
    localparam int SB_DATA_WIDTH      = 32;

    typedef struct packed {
        logic [SB_ADDR_WIDTH-1:0] address;
        logic [SB_DATA_WIDTH-1:0] data;
        mem_op_width_t            width;
    } store_buffer_entry_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_REQUEST,
        DRAIN_GAP
    } drain_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// Push side (from store controller) and drain side (to external memory) of the store buffer.
// Slave modport is the buffer; master modport is controller plus memory.
interface store_buffer_if
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH = SB_DATA_WIDTH
) ();

    logic                  push_i;
    logic [ADDR_WIDTH-1:0] push_address_i;
    logic [DATA_WIDTH-1:0] push_data_i;
    mem_op_width_t         push_width_i;
    logic                  full_o;
    logic                  empty_o;
    logic                  mem_request_o;
    logic [ADDR_WIDTH-1:0] mem_address_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    mem_op_width_t         mem_width_o;
    logic                  mem_acknowledge_i;

    modport slave (
        input  push_i, push_address_i, push_data_i, push_width_i,
        input  mem_acknowledge_i,
        output full_o, empty_o,
        output mem_request_o, mem_address_o, mem_data_o, mem_width_o
    );

    modport master (
        output push_i, push_address_i, push_data_i, push_width_i,
        output mem_acknowledge_i,
        input  full_o, empty_o,
        input  mem_request_o, mem_address_o, mem_data_o, mem_width_o
    );

endinterface

// File: rtl/store_buffer_forward_lookup.sv
// Store-to-load forwarding lookup over the pending store buffer entries.
// Only built when STORE_BUFFER_FORWARD_EN is defined.
`ifdef STORE_BUFFER_FORWARD_EN
module store_buffer_forward_lookup
    import data_memory_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 3,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  store_buffer_entry_t entries_i [DEPTH],
    input  logic [DEPTH-1:0]    valid_i,
    input  logic [PTR_W-1:0]    head_i,
    input  logic [PTR_W-1:0]    tail_i,
    input  logic [AW-1:0]       address_i,
    output logic                hit_o,
    output logic                stall_o,
    output logic [DW-1:0]       data_o
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] idx;
    logic             word_seen;
    logic             narrow_seen;
    logic [DW-1:0]    word_data;

    assign count = tail_i - head_i;

    // Walk oldest to youngest so the youngest WORD match wins.
    always_comb begin
        word_seen   = 1'b0;
        narrow_seen = 1'b0;
        word_data   = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i[IDX_W-1:0] + IDX_W'(k);
            if (PTR_W'(k) < count && valid_i[idx] &&
                entries_i[idx].address[AW-1:2] == address_i[AW-1:2]) begin
                if (entries_i[idx].width == WORD) begin
                    word_seen = 1'b1;
                    word_data = entries_i[idx].data;
                end else begin
                    narrow_seen = 1'b1;
                end
            end
        end
    end

    assign stall_o = narrow_seen;
    assign hit_o   = word_seen && !narrow_seen;
    assign data_o  = hit_o ? word_data : '0;

endmodule
`endif

// File: rtl/store_buffer.sv
// In-order write buffer between the store controller and external memory.
// Define STORE_BUFFER_FORWARD_EN to add store-to-load forwarding ports.
module store_buffer
    import data_memory_pkg::*;
#(
    parameter int BUFFER_DEPTH = STORE_BUFFER_DEPTH,
    parameter int ADDR_WIDTH   = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SB_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    store_buffer_if.slave         sb_if
`ifdef STORE_BUFFER_FORWARD_EN
    ,
    input  logic [ADDR_WIDTH-1:0] ldu_address_i,
    output logic                  fwd_hit_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    output logic                  fwd_stall_o
`endif
);

    localparam int PTR_W = $clog2(BUFFER_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    store_buffer_entry_t   entries_q [BUFFER_DEPTH];
    store_buffer_entry_t   push_entry;
    store_buffer_entry_t   head;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    drain_state_t          state_q, state_d;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push_ok;
    logic                  pop;
    logic                  requesting;
    logic [ADDR_WIDTH-1:0] head_address;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign push_ok    = sb_if.push_i && !fifo_full;

    assign push_entry.address = sb_if.push_address_i;
    assign push_entry.data    = sb_if.push_data_i;
    assign push_entry.width   = sb_if.push_width_i;

    assign head         = entries_q[rd_ptr_q[IDX_W-1:0]];
    assign head_address = head.address;
    assign head_data    = head.data;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            DRAIN_IDLE: begin
                if (!fifo_empty) state_d = DRAIN_REQUEST;
            end
            DRAIN_REQUEST: begin
                if (sb_if.mem_acknowledge_i) begin
                    pop     = 1'b1;
                    state_d = DRAIN_GAP;
                end
            end
            DRAIN_GAP: state_d = DRAIN_IDLE;
            default:   state_d = DRAIN_IDLE;
        endcase
    end

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= DRAIN_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: only slots between the pointers are observed.
    always_ff @(posedge clk_i) begin
        if (push_ok) entries_q[wr_ptr_q[IDX_W-1:0]] <= push_entry;
    end

    assign requesting          = state_q == DRAIN_REQUEST;
    assign sb_if.mem_request_o = requesting;
    assign sb_if.mem_address_o = requesting ? head_address : '0;
    assign sb_if.mem_data_o    = requesting ? head_data : '0;
    assign sb_if.mem_width_o   = requesting ? head.width : BYTE;
    assign sb_if.full_o        = fifo_full;
    assign sb_if.empty_o       = fifo_empty && state_q == DRAIN_IDLE;

`ifdef STORE_BUFFER_FORWARD_EN
    logic [BUFFER_DEPTH-1:0] valid;
    logic [PTR_W-1:0]        count;

    assign count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        valid = '0;
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            valid[i] = {1'b0, IDX_W'(i) - rd_ptr_q[IDX_W-1:0]} < count;
        end
    end

    store_buffer_forward_lookup #(
        .DEPTH (BUFFER_DEPTH),
        .PTR_W (PTR_W),
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH)
    ) u_fwd (
        .entries_i (entries_q),
        .valid_i   (valid),
        .head_i    (rd_ptr_q),
        .tail_i    (wr_ptr_q),
        .address_i (ldu_address_i),
        .hit_o     (fwd_hit_o),
        .stall_o   (fwd_stall_o),
        .data_o    (fwd_data_o)
    );
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed scoreboard bench for store_buffer (forwarding checks under STORE_BUFFER_FORWARD_EN).
`timescale 1ns/1ps
module tb_store_buffer;
    import data_memory_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    store_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sbi ();

`ifdef STORE_BUFFER_FORWARD_EN
    logic [31:0] ldu_address_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic        fwd_stall_o;
`endif

    store_buffer #(
        .BUFFER_DEPTH (4),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sb_if (sbi)
`ifdef STORE_BUFFER_FORWARD_EN
        ,
        .ldu_address_i (ldu_address_i),
        .fwd_hit_o     (fwd_hit_o),
        .fwd_data_o    (fwd_data_o),
        .fwd_stall_o   (fwd_stall_o)
`endif
    );

    store_buffer_entry_t sb_q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input mem_op_width_t w);
        store_buffer_entry_t e;
        bit model_full;
        model_full = sb_q.size() >= 4;
        if (model_full) chk("full_before_drop", sbi.full_o, 1);
        sbi.push_i         = 1'b1;
        sbi.push_address_i = a;
        sbi.push_data_i    = d;
        sbi.push_width_i   = w;
        tick();
        sbi.push_i = 1'b0;
        e.address  = a;
        e.data     = d;
        e.width    = w;
        if (!model_full) sb_q.push_back(e);
        else chk("drop_keeps_full", sbi.full_o, 1);
    endtask

    task automatic drain_one(input int hold);
        store_buffer_entry_t e;
        int n;
        n = 0;
        while (sbi.mem_request_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", sbi.mem_request_o, 1);
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sbi.mem_request_o === 1'b1 && sb_q.size() != 0) begin
            e = sb_q[0];
            chk("mem_addr", sbi.mem_address_o, e.address);
            chk("mem_data", sbi.mem_data_o, e.data);
            chk("mem_width", sbi.mem_width_o, e.width);
            repeat (hold) begin
                tick();
                chk("req_held", sbi.mem_request_o, 1);
                chk("addr_held", sbi.mem_address_o, e.address);
            end
            sbi.mem_acknowledge_i = 1'b1;
            tick();
            sbi.mem_acknowledge_i = 1'b0;
            void'(sb_q.pop_front());
            chk("gap_req", sbi.mem_request_o, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i                 = 1'b1;
        sbi.push_i            = 1'b0;
        sbi.push_address_i    = '0;
        sbi.push_data_i       = '0;
        sbi.push_width_i      = BYTE;
        sbi.mem_acknowledge_i = 1'b0;
`ifdef STORE_BUFFER_FORWARD_EN
        ldu_address_i = '0;
`endif
        #12;
        chk("rst_full", sbi.full_o, 0);
        chk("rst_empty", sbi.empty_o, 1);
        chk("rst_req", sbi.mem_request_o, 0);
        chk("rst_addr", sbi.mem_address_o, 0);
        chk("rst_data", sbi.mem_data_o, 0);
        chk("rst_width", sbi.mem_width_o, BYTE);
`ifdef STORE_BUFFER_FORWARD_EN
        chk("rst_fwd_hit", fwd_hit_o, 0);
        chk("rst_fwd_stall", fwd_stall_o, 0);
`endif
        rst_i = 1'b0;
        tick();

        // single WORD store, ack two cycles into the request
        push(32'h0000_1000, 32'hDEAD_BEEF, WORD);
        chk("t1_empty_after_push", sbi.empty_o, 0);
        chk("t1_req_not_yet", sbi.mem_request_o, 0);
        tick();
        chk("t1_req_rise", sbi.mem_request_o, 1);
        drain_one(2);
        chk("t1_gap_not_empty", sbi.empty_o, 0);
        tick();
        chk("t1_empty", sbi.empty_o, 1);
        chk("t1_idle_req", sbi.mem_request_o, 0);

        // fill to full with ack held low, fifth push dropped
        push(32'h0000_0100, 32'h0000_00A0, WORD);
        push(32'h0000_0104, 32'h0000_00A1, HALF_WORD);
        push(32'h0000_0108, 32'h0000_00A2, BYTE);
        chk("t2_not_full_3", sbi.full_o, 0);
        push(32'h0000_010C, 32'h0000_00A3, WORD);
        chk("t2_full_4", sbi.full_o, 1);
        push(32'h0000_0110, 32'h0000_00A4, WORD);
        drain_one(0);
        tick();
        chk("t2_spacing_idle", sbi.mem_request_o, 0);
        tick();
        chk("t2_spacing_req", sbi.mem_request_o, 1);
        drain_one(0);
        drain_one(0);
        drain_one(0);
        tick();
        chk("t2_empty", sbi.empty_o, 1);
        chk("t2_sb_drained", sb_q.size(), 0);

        // push and ack together while full: push refused, one pop
        push(32'h0000_0200, 32'h0000_00B0, WORD);
        push(32'h0000_0204, 32'h0000_00B1, WORD);
        push(32'h0000_0208, 32'h0000_00B2, WORD);
        push(32'h0000_020C, 32'h0000_00B3, WORD);
        chk("t3_full", sbi.full_o, 1);
        chk("t3_req", sbi.mem_request_o, 1);
        chk("t3_head", sbi.mem_address_o, sb_q[0].address);
        sbi.push_i            = 1'b1;
        sbi.push_address_i    = 32'h0000_0FF0;
        sbi.push_data_i       = 32'h0000_00FF;
        sbi.push_width_i      = WORD;
        sbi.mem_acknowledge_i = 1'b1;
        tick();
        sbi.push_i            = 1'b0;
        sbi.mem_acknowledge_i = 1'b0;
        void'(sb_q.pop_front());
        chk("t3_full_drops", sbi.full_o, 0);
        chk("t3_not_empty", sbi.empty_o, 0);
        drain_one(0);
        drain_one(0);
        drain_one(0);
        tick();
        chk("t3_empty", sbi.empty_o, 1);
        repeat (4) tick();
        chk("t3_no_extra_req", sbi.mem_request_o, 0);

        // asynchronous reset during an active request with 3 entries
        push(32'h0000_0300, 32'h0000_00C0, WORD);
        push(32'h0000_0304, 32'h0000_00C1, WORD);
        push(32'h0000_0308, 32'h0000_00C2, WORD);
        chk("t4_req_before_rst", sbi.mem_request_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t4_rst_req", sbi.mem_request_o, 0);
        chk("t4_rst_empty", sbi.empty_o, 1);
        chk("t4_rst_addr", sbi.mem_address_o, 0);
        sb_q.delete();
        tick();
        rst_i = 1'b0;
        sbi.mem_acknowledge_i = 1'b1;
        tick();
        tick();
        sbi.mem_acknowledge_i = 1'b0;
        chk("t4_ack_ignored_req", sbi.mem_request_o, 0);
        chk("t4_ack_ignored_empty", sbi.empty_o, 1);
        push(32'h0000_0400, 32'h0000_00D0, HALF_WORD);
        drain_one(1);
        tick();
        chk("t4_final_empty", sbi.empty_o, 1);

`ifdef STORE_BUFFER_FORWARD_EN
        push(32'h0000_2000, 32'h1111_1111, WORD);
        push(32'h0000_2000, 32'h2222_2222, WORD);
        ldu_address_i = 32'h0000_2002;
        #1;
        chk("t5_fwd_hit", fwd_hit_o, 1);
        chk("t5_fwd_data", fwd_data_o, 32'h2222_2222);
        chk("t5_fwd_nostall", fwd_stall_o, 0);
        ldu_address_i = 32'h0000_5000;
        #1;
        chk("t5_miss_hit", fwd_hit_o, 0);
        chk("t5_miss_stall", fwd_stall_o, 0);
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        sb_q.delete();
        tick();
        push(32'h0000_3001, 32'h0000_00AB, BYTE);
        ldu_address_i = 32'h0000_3000;
        #1;
        chk("t6_fwd_stall", fwd_stall_o, 1);
        chk("t6_fwd_nohit", fwd_hit_o, 0);
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        sb_q.delete();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
